// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int DIV_DATA_WIDTH = 32;
    localparam int DIV_CNT_WIDTH  = $clog2(DIV_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Counter width for an arbitrary operand width (at least one bit).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {remainder, quotient} left, trial-subtract,
// keep the difference and set the quotient LSB when it is non-negative.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] quo_in,
    input  logic [DATA_WIDTH-1:0] div_mag,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic [DATA_WIDTH-1:0] quo_out
);

    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH+1:0] diff;

    assign shifted = {rem_in, quo_in[DATA_WIDTH-1]};
    // One guard bit above the partial remainder gives the sign of the trial result.
    assign diff    = shifted - {2'b00, div_mag};

    always_comb begin
        rem_out = shifted[DATA_WIDTH:0];
        quo_out = {quo_in[DATA_WIDTH-2:0], 1'b0};
        if (!diff[DATA_WIDTH+1]) begin
            rem_out = diff[DATA_WIDTH:0];
            quo_out = {quo_in[DATA_WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// Signed support is compiled in when DIV_SIGNED_EN is defined; otherwise all divides are unsigned.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sign,
    input  logic                  cancel,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int CNT_WIDTH = cnt_width(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    div_state_e state_reg, state_next;

    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic [DATA_WIDTH:0]   rem_reg;
    logic [DATA_WIDTH-1:0] quo_reg;
    logic [DATA_WIDTH-1:0] div_reg;
    logic [DATA_WIDTH-1:0] quotient_reg;
    logic [DATA_WIDTH-1:0] remainder_reg;

    logic [DATA_WIDTH:0]   rem_step;
    logic [DATA_WIDTH-1:0] quo_step;
    logic [DATA_WIDTH-1:0] dividend_mag;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic                  accept;

    assign accept = (state_reg == IDLE) && start && !cancel;

`ifdef DIV_SIGNED_EN
    logic qneg_reg, rneg_reg;
    logic qneg_in, rneg_in;

    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
        if (sign && dividend[DATA_WIDTH-1]) dividend_mag = (~dividend) + DATA_WIDTH'(1);
        if (sign && divisor[DATA_WIDTH-1])  divisor_mag  = (~divisor) + DATA_WIDTH'(1);
    end

    // Divide by zero must yield all ones, so the quotient is never negated in that case.
    assign qneg_in = sign && (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]) && (divisor != '0);
    assign rneg_in = sign && dividend[DATA_WIDTH-1];
`else
    logic unused_sign;

    assign unused_sign  = sign;
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
`endif

    div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_in (rem_reg),
        .quo_in (quo_reg),
        .div_mag(div_reg),
        .rem_out(rem_step),
        .quo_out(quo_step)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt_reg == CNT_LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (cancel) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            div_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg <= '0;
                rem_reg <= '0;
                quo_reg <= dividend_mag;
                div_reg <= divisor_mag;
            end else if (state_reg == CALC) begin
                cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                rem_reg <= rem_step;
                quo_reg <= quo_step;
            end
            if (state_reg == FIX && !cancel) begin
`ifdef DIV_SIGNED_EN
                quotient_reg  <= qneg_reg ? (~quo_reg) + DATA_WIDTH'(1) : quo_reg;
                remainder_reg <= rneg_reg ? (~rem_reg[DATA_WIDTH-1:0]) + DATA_WIDTH'(1)
                                          : rem_reg[DATA_WIDTH-1:0];
`else
                quotient_reg  <= quo_reg;
                remainder_reg <= rem_reg[DATA_WIDTH-1:0];
`endif
            end
        end
    end

`ifdef DIV_SIGNED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            qneg_reg <= 1'b0;
            rneg_reg <= 1'b0;
        end else if (accept) begin
            qneg_reg <= qneg_in;
            rneg_reg <= rneg_in;
        end
    end
`endif

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides push expected results, a monitor checks on done.
module tb_div_unit;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done;
    logic [31:0] quotient, remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .cancel   (cancel),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_quotient"}, quotient, e.q);
                check({e.name, "_remainder"}, remainder, e.r);
            end
        end
    end

    // Caller is at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; sign = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit extra);
        int  n;
        int  busy_cnt = 0;
        bit  seen = 1'b0;
        for (n = 1; n <= 100; n++) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            // Stray start pulses while busy must be ignored.
            start = extra && (n == 5 || n == 20);
            if (start) begin
                dividend = 32'd99; divisor = 32'd1; sign = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(n), 32'd34);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd34);
        @(negedge clk);
        check({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic run(input string name, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        e.q = eq; e.r = er; e.name = name;
        sb_q.push_back(e);
        issue(s, a, b);
        wait_done(name, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, 30'd0} | quotient | remainder, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run("u_100_div_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run("s_m100_div_7", 1'b1, 32'hFFFF_FF9C, 32'd7,
            SIGNED_EN ? 32'hFFFF_FFF2 : 32'd613566742,
            SIGNED_EN ? 32'hFFFF_FFFE : 32'd2);
        run("s_100_div_m7", 1'b1, 32'd100, 32'hFFFF_FFF9,
            SIGNED_EN ? 32'hFFFF_FFF2 : 32'd0,
            SIGNED_EN ? 32'd2 : 32'd100);
        run("s_m7_div_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
            SIGNED_EN ? 32'd3 : 32'd0,
            SIGNED_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFF9);
        run("u_div_zero", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        run("s_div_zero", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        run("s_neg_div_zero", 1'b1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000);
        run("s_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            SIGNED_EN ? 32'h8000_0000 : 32'd0,
            SIGNED_EN ? 32'd0 : 32'h8000_0000);

        // Cancel mid-operation, restart immediately; no expectation pushed for the aborted op.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_idle", {31'd0, busy}, 32'd0);
        begin
            exp_t e;
            e.q = 32'd6; e.r = 32'd2; e.name = "u_20_div_3_after_cancel";
            sb_q.push_back(e);
        end
        issue(1'b0, 32'd20, 32'd3);
        wait_done("u_20_div_3_after_cancel", 1'b1);

        // Start and cancel together: nothing accepted.
        start = 1'b1; cancel = 1'b1; dividend = 32'd5; divisor = 32'd1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_same_cycle", {31'd0, busy}, 32'd0);

        // Reset mid-operation clears everything, including held results.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_flags", {30'd0, busy, done}, 32'd0);
        check("mid_reset_quotient", quotient, 32'd0);
        check("mid_reset_remainder", remainder, 32'd0);
        run("u_max_div_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

        repeat (40) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
